mux: RTL and testbench
======================

Name: mux

Overview:
- Registered 8-to-1 single-bit multiplexer.
- Each clock, the input bit `i[s]` is captured into output `y`.
- Used as a bit-select stage in datapaths where one of eight status/data lines is routed to a single downstream bit.
- Also provides a registered echo of the select, a one-hot decode of the select, and an output-valid flag for downstream alignment.

Parameters:
- N_IN, 8, number of data inputs; fixed at 8 for this block.
- SEL_W, 3, select width; equals log2(N_IN).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- s  input  3  select; chooses input bit `i[s]`.
- i  input  8  data inputs; `i[0]`..`i[7]`.
- y  output  1  registered selected bit.
- y_valid  output  1  high when `y` holds a value captured after reset.
- sel_q  output  3  registered copy of `s` that produced the current `y`.
- sel_onehot  output  8  registered one-hot decode of `s`: bit k set iff `sel_q` == k.

Behaviour:
- One clock domain; no combinational path from inputs to outputs.
- Reset, sampled on posedge with rst=1:
  - `y` = 0, `y_valid` = 0, `sel_q` = 0, `sel_onehot` = 8'b0000_0000.
  - All-zero decode during reset is intentional.
- Normal operation, each posedge with rst=0:
  - `y` <= `i[s]`.
  - `sel_q` <= `s`.
  - `sel_onehot` <= 8'b1 << `s`.
  - `y_valid` <= 1.
- Latency:
  - Exactly 1 clock from `s`/`i` sampled to `y` update.
  - `s` and `i` are sampled together on the same edge.
- Select mapping: s=0 -> `i[0]`, s=1 -> `i[1]`, … s=7 -> `i[7]`. All 8 codes are valid; no out-of-range case exists.
- `y_valid`:
  - Low during reset.
  - Goes high on the first posedge with rst=0, and stays high until the next reset.
- Changing `s` or `i` between edges has no effect on the outputs until the next posedge.
- Back-to-back select changes every cycle are fully supported; there are no bubbles or hold requirements.
- Reset mid-operation:
  - Reset wins over capture on the same edge; outputs go to their reset values on that edge.
  - The first post-reset capture occurs on the first edge with rst=0.
- Invariant: after any non-reset edge, `y` == `i_prev[sel_q]`, where `i_prev` is the `i` sampled on that edge.
- Invariant: `sel_onehot` has exactly one bit set whenever `y_valid`=1, and no bits set whenever `y_valid`=0.
- Decode and select are built as an explicit 3-level 2:1 mux tree (s[0] first level, s[2] last) feeding the `y` register. Functional behaviour is identical to the indexed select.
- No X-propagation handling is required beyond standard RTL semantics.

Test Plan:
- Reset: hold rst=1 for 2 clocks with s=3'd5, i=8'hFF -> `y`=0, `y_valid`=0, `sel_q`=0, `sel_onehot`=8'h00. Release rst -> after one edge `y`=1, `y_valid`=1, `sel_q`=5, `sel_onehot`=8'h20.
- Walking one: i=8'h01<<k with s=k for k=0..7, one per clock -> `y`=1 on every cycle, `sel_onehot` follows 8'h01, 8'h02 … 8'h80 with 1-clock lag.
- Walking zero / mismatch: i=~(8'h01<<k) with s=k -> `y`=0 every cycle. i=8'h01<<k with s=(k+1)%8 -> `y`=0 every cycle.
- Fixed pattern sweep: i=8'hA5, s=0..7 on consecutive clocks -> `y` sequence 1,0,1,0,0,1,0,1, each one clock after its select.
- Mid-stream reset: with i=8'hFF, s=3'd2 running, assert rst for one edge -> outputs return to reset values on that edge. Next edge with rst=0 -> `y`=1, `sel_q`=2, `y_valid`=1.
- Inter-edge glitch: change `i` and `s` several times between two posedges, then settle at s=3'd7, i=8'h80 before the edge -> only the settled value is captured: `y`=1, `sel_q`=7.

Source files
------------

// File: rtl/mux.sv
// Registered 8-to-1 single-bit multiplexer.
// Captures i[s] into y each clock. Also registers a copy of the select, a
// one-hot decode of it, and a valid flag that rises on the first capture
// after reset.
module mux #(
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] s,
  input  logic [N_IN-1:0]  i,
  output logic             y,
  output logic             y_valid,
  output logic [SEL_W-1:0] sel_q,
  output logic [N_IN-1:0]  sel_onehot
);

  // Mux tree stages: level 1 is steered by s[0], level 3 by s[2].
  logic [3:0]      lvl1_next;
  logic [1:0]      lvl2_next;
  logic            y_next;
  logic [N_IN-1:0] onehot_next;

  logic             y_reg;
  logic             y_valid_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [N_IN-1:0]  onehot_reg;

  // Level 1: four 2:1 muxes choosing between adjacent input pairs.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
      assign lvl1_next[gi] = s[0] ? i[2*gi+1] : i[2*gi];
    end
  endgenerate

  // Level 2: two 2:1 muxes choosing between level-1 pairs.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
      assign lvl2_next[gi] = s[1] ? lvl1_next[2*gi+1] : lvl1_next[2*gi];
    end
  endgenerate

  // Level 3: final 2:1 mux feeding the output register.
  assign y_next = s[2] ? lvl2_next[1] : lvl2_next[0];

  // One-hot decode of the select, one comparator per output bit.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_decode
      assign onehot_next[gi] = (s == SEL_W'(gi));
    end
  endgenerate

  // Output registers; reset clears everything, including the decode, so
  // downstream logic sees no selected line until the first capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg       <= 1'b0;
      y_valid_reg <= 1'b0;
      sel_reg     <= '0;
      onehot_reg  <= '0;
    end else begin
      y_reg       <= y_next;
      y_valid_reg <= 1'b1;
      sel_reg     <= s;
      onehot_reg  <= onehot_next;
    end
  end

  assign y          = y_reg;
  assign y_valid    = y_valid_reg;
  assign sel_q      = sel_reg;
  assign sel_onehot = onehot_reg;

endmodule

// File: tb/tb_mux.sv
// Directed testbench for the registered 8-to-1 multiplexer.
module tb_mux;

  logic       clk;
  logic       rst;
  logic [2:0] s;
  logic [7:0] i;
  logic       y;
  logic       y_valid;
  logic [2:0] sel_q;
  logic [7:0] sel_onehot;

  int checks;
  int errors;

  mux dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .i          (i),
    .y          (y),
    .y_valid    (y_valid),
    .sel_q      (sel_q),
    .sel_onehot (sel_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%b s=%0d i=%h -> y=%b v=%b sel_q=%0d oh=%h",
             $time, rst, s, i, y, y_valid, sel_q, sel_onehot);
  endtask

  task automatic test_reset();
    rst = 1'b1; s = 3'd5; i = 8'hFF;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++; if (y !== 1'b0) begin errors++; $display("FAIL reset_y cyc=%0d got %b want 0", n, y); end
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc=%0d got %b want 0", n, y_valid); end
      checks++; if (sel_q !== 3'd0) begin errors++; $display("FAIL reset_sel_q cyc=%0d got %0d want 0", n, sel_q); end
      checks++; if (sel_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot cyc=%0d got %h want 00", n, sel_onehot); end
    end
    rst = 1'b0;
    step();
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL release_y got %b want 1", y); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %b want 1", y_valid); end
    checks++; if (sel_q !== 3'd5) begin errors++; $display("FAIL release_sel_q got %0d want 5", sel_q); end
    checks++; if (sel_onehot !== 8'h20) begin errors++; $display("FAIL release_onehot got %h want 20", sel_onehot); end
  endtask

  task automatic test_walking_one();
    logic [7:0] exp_oh;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k); i = 8'h01 << k;
      exp_oh = 8'h01 << k;
      step();
      checks++; if (y !== 1'b1) begin errors++; $display("FAIL walk1_y k=%0d got %b want 1", k, y); end
      checks++; if (sel_q !== 3'(k)) begin errors++; $display("FAIL walk1_sel_q k=%0d got %0d want %0d", k, sel_q, k); end
      checks++; if (sel_onehot !== exp_oh) begin errors++; $display("FAIL walk1_onehot k=%0d got %h want %h", k, sel_onehot, exp_oh); end
      checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL walk1_valid k=%0d got %b want 1", k, y_valid); end
    end
  endtask

  task automatic test_walking_zero();
    for (int k = 0; k < 8; k++) begin
      s = 3'(k); i = ~(8'h01 << k);
      step();
      checks++; if (y !== 1'b0) begin errors++; $display("FAIL walk0_y k=%0d got %b want 0", k, y); end
    end
    for (int k = 0; k < 8; k++) begin
      s = 3'((k + 1) % 8); i = 8'h01 << k;
      step();
      checks++; if (y !== 1'b0) begin errors++; $display("FAIL mismatch_y k=%0d got %b want 0", k, y); end
    end
  endtask

  task automatic test_pattern_sweep();
    logic exp_y [8];
    exp_y = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    i = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      step();
      checks++; if (y !== exp_y[k]) begin errors++; $display("FAIL sweep_y s=%0d got %b want %b", k, y, exp_y[k]); end
      checks++; if (sel_q !== 3'(k)) begin errors++; $display("FAIL sweep_sel_q s=%0d got %0d want %0d", k, sel_q, k); end
    end
  endtask

  task automatic test_mid_reset();
    i = 8'hFF; s = 3'd2;
    step();
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL midrst_pre_y got %b want 1", y); end
    rst = 1'b1;
    step();
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL midrst_y got %b want 0", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", y_valid); end
    checks++; if (sel_q !== 3'd0) begin errors++; $display("FAIL midrst_sel_q got %0d want 0", sel_q); end
    checks++; if (sel_onehot !== 8'h00) begin errors++; $display("FAIL midrst_onehot got %h want 00", sel_onehot); end
    rst = 1'b0;
    step();
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL midrst_rel_y got %b want 1", y); end
    checks++; if (sel_q !== 3'd2) begin errors++; $display("FAIL midrst_rel_sel_q got %0d want 2", sel_q); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL midrst_rel_valid got %b want 1", y_valid); end
    checks++; if (sel_onehot !== 8'h04) begin errors++; $display("FAIL midrst_rel_onehot got %h want 04", sel_onehot); end
  endtask

  task automatic test_glitch();
    // Establish a known captured state: y=0, sel_q=3.
    s = 3'd3; i = 8'h00;
    step();
    // Wiggle inputs between edges; outputs must hold.
    s = 3'd1; i = 8'hFF; #1;
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL glitch_hold_y got %b want 0", y); end
    checks++; if (sel_q !== 3'd3) begin errors++; $display("FAIL glitch_hold_sel_q got %0d want 3", sel_q); end
    s = 3'd6; i = 8'h40; #1;
    s = 3'd0; i = 8'h7F; #1;
    checks++; if (sel_onehot !== 8'h08) begin errors++; $display("FAIL glitch_hold_onehot got %h want 08", sel_onehot); end
    s = 3'd7; i = 8'h80;
    step();
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL glitch_y got %b want 1", y); end
    checks++; if (sel_q !== 3'd7) begin errors++; $display("FAIL glitch_sel_q got %0d want 7", sel_q); end
    checks++; if (sel_onehot !== 8'h80) begin errors++; $display("FAIL glitch_onehot got %h want 80", sel_onehot); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; s = 3'd0; i = 8'h00;
    test_reset();
    test_walking_one();
    test_walking_zero();
    test_pattern_sweep();
    test_mid_reset();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the run never reaches the summary.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
